instruction_fetch_stage: RTL and testbench

Instruction fetch stage of the MIPS pipeline. It owns the program counter, sequences instruction-memory reads with a ready handshake, computes PC+4 and fills the IF/ID pipeline register. It accepts stall requests from the hazard unit and branch/jump redirects from the execute stage.

---
 rtl/instruction_fetch_stage_pkg.sv | 28 ++
 rtl/instruction_fetch_stage_if.sv | 28 ++
 rtl/instruction_fetch_stage_pc_next_sel.sv | 24 ++
 rtl/instruction_fetch_stage.sv | 112 +++++++++++
 tb/tb_instruction_fetch_stage.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, next-PC
// select codes, reset/increment constants and the word-alignment mask.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_INC   = 2'd1,
    SEL_REDIR = 2'd2,
    SEL_RESET = 2'd3
  } pc_sel_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

  // True when an address is not on a 32-bit word boundary.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr & ~ALIGN_MASK) != 32'd0;
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage signal bundle: hazard/redirect controls, instruction memory
// handshake and the IF/ID register outputs. "master" is the fetch stage,
// "slave" is the surrounding pipeline and memory.
interface instruction_fetch_stage_if;

  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic [31:0] ImemAddr;
  logic [31:0] ImemRdata;
  logic        ImemReady;
  logic        IfIdValid;
  logic [31:0] IfIdInstr;
  logic [31:0] IfIdPC;
  logic [31:0] IfIdPCPlus4;
  logic        MisalignFault;

  modport master (
    input  Stall, Redirect, RedirectPC, ImemRdata, ImemReady,
    output ImemAddr, IfIdValid, IfIdInstr, IfIdPC, IfIdPCPlus4, MisalignFault
  );

  modport slave (
    output Stall, Redirect, RedirectPC, ImemRdata, ImemReady,
    input  ImemAddr, IfIdValid, IfIdInstr, IfIdPC, IfIdPCPlus4, MisalignFault
  );

endinterface

// File: rtl/instruction_fetch_stage_pc_next_sel.sv
// Combinational next-PC mux: hold, sequential increment, redirect target or
// reset value. Arithmetic wraps modulo 2^32.
module pc_next_sel
  import fetch_pkg::*;
(
  input  pc_sel_t     sel,
  input  logic [31:0] pc,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] reset_pc,
  output logic [31:0] next_pc
);

  // Select the PC value to be loaded on the next edge.
  always_comb begin
    next_pc = pc;
    case (sel)
      SEL_INC:   next_pc = pc + PC_INC;
      SEL_REDIR: next_pc = redirect_pc;
      SEL_RESET: next_pc = reset_pc;
      default:   next_pc = pc;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS instruction fetch stage: owns the PC, issues instruction-memory reads
// with a ready handshake and fills the IF/ID register. Honours hazard stalls
// and execute-stage redirects (redirect wins over stall).
// Optional feature macro: FETCH_MISALIGN_TRAP_EN -- when defined, a redirect to
// a non-word-aligned target raises a sticky MisalignFault and parks the stage
// in HALT until reset; when undefined, redirect targets are word-aligned.
module instruction_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                      Clk,
  input  logic                      Rst,
  instruction_fetch_stage_if.master fif
);

  fetch_state_t state_q;
  pc_sel_t      pc_sel;
  logic [31:0]  pc_p0;
  logic [31:0]  pc_next;
  logic [31:0]  redir_tgt;
  logic         vld_p1;
  logic [31:0]  instr_p1;
  logic [31:0]  pc_p1;
  logic [31:0]  pc4_p1;
  logic         fault_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  // Faulting targets are kept unaligned so the debugger sees the bad address.
  assign redir_tgt = fif.RedirectPC;
`else
  assign redir_tgt = fif.RedirectPC & ALIGN_MASK;
`endif

  // Choose the next-PC source from state and the prioritised controls.
  always_comb begin
    pc_sel = SEL_HOLD;
    if (Rst) begin
      pc_sel = SEL_RESET;
    end else if (state_q == FETCH || state_q == WAIT) begin
      if (fif.Redirect)       pc_sel = SEL_REDIR;
      else if (fif.Stall)     pc_sel = SEL_HOLD;
      else if (fif.ImemReady) pc_sel = SEL_INC;
      else                    pc_sel = SEL_HOLD;
    end
  end

  pc_next_sel u_pc_next_sel (
    .sel         (pc_sel),
    .pc          (pc_p0),
    .redirect_pc (redir_tgt),
    .reset_pc    (RESET_PC),
    .next_pc     (pc_next)
  );

  // PC register; reset reaches it through the SEL_RESET mux leg.
  always_ff @(posedge Clk) begin
    pc_p0 <= pc_next;
  end

  // Fetch FSM and IF/ID register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= BOOT;
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      pc_p1    <= '0;
      pc4_p1   <= '0;
      fault_q  <= 1'b0;
    end else begin
      case (state_q)
        BOOT: state_q <= FETCH;
        FETCH, WAIT: begin
          if (fif.Redirect) begin
            vld_p1  <= 1'b0;
            state_q <= FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (is_misaligned(fif.RedirectPC)) begin
              fault_q <= 1'b1;
              state_q <= HALT;
            end
`endif
          end else if (fif.Stall) begin
            state_q <= state_q;
          end else if (fif.ImemReady) begin
            instr_p1 <= fif.ImemRdata;
            pc_p1    <= pc_p0;
            pc4_p1   <= pc_p0 + PC_INC;
            vld_p1   <= 1'b1;
            state_q  <= FETCH;
          end else begin
            vld_p1  <= 1'b0;
            state_q <= WAIT;
          end
        end
        default: state_q <= HALT;
      endcase
    end
  end

  assign fif.ImemAddr    = pc_p0;
  assign fif.IfIdValid   = vld_p1;
  assign fif.IfIdInstr   = instr_p1;
  assign fif.IfIdPC      = pc_p1;
  assign fif.IfIdPCPlus4 = pc4_p1;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fif.MisalignFault = fault_q;
`else
  assign fif.MisalignFault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed stimulus, a behavioural model
// checked every cycle, and literal expectations for the key scenarios.
// A second instance with RESET_PC=0xFFFF_FFFC covers address wrap-around.
module tb_instruction_fetch_stage;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  instruction_fetch_stage_if fif ();
  instruction_fetch_stage_if wif ();

  instruction_fetch_stage dut (
    .Clk (Clk),
    .Rst (Rst),
    .fif (fif)
  );

  instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .Clk (Clk),
    .Rst (Rst),
    .fif (wif)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  assign fif.ImemRdata = mem_word(fif.ImemAddr);
  assign wif.ImemRdata = mem_word(wif.ImemAddr);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the IF/ID outputs and fetch address must be.
  bit          m_ok = 1'b0;
  bit          m_boot, m_halt, m_valid, m_fault;
  logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4;

  always @(posedge Clk) begin
    if (Rst) begin
      m_ok = 1'b1; m_boot = 1'b1; m_halt = 1'b0; m_valid = 1'b0; m_fault = 1'b0;
      m_pc = 32'h0; m_instr = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0;
    end else if (m_ok) begin
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (m_halt) begin
        m_valid = 1'b0;
      end else if (fif.Redirect) begin
        m_valid = 1'b0;
        if (TRAP && (fif.RedirectPC % 4) != 0) begin
          m_fault = 1'b1;
          m_halt  = 1'b1;
          m_pc    = fif.RedirectPC;
        end else begin
          m_pc = fif.RedirectPC - (fif.RedirectPC % 4);
        end
      end else if (fif.Stall) begin
        m_pc = m_pc;
      end else if (fif.ImemReady) begin
        m_instr = mem_word(m_pc);
        m_ifpc  = m_pc;
        m_ifpc4 = m_pc + 4;
        m_valid = 1'b1;
        m_pc    = m_pc + 4;
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (m_ok) begin
      chk("m_addr",  fif.ImemAddr,           m_pc);
      chk("m_valid", 32'(fif.IfIdValid),     32'(m_valid));
      chk("m_instr", fif.IfIdInstr,          m_instr);
      chk("m_pc",    fif.IfIdPC,             m_ifpc);
      chk("m_pc4",   fif.IfIdPCPlus4,        m_ifpc4);
      chk("m_fault", 32'(fif.MisalignFault), 32'(m_fault));
    end
  end

  task automatic cyc(input bit st, input bit rd, input logic [31:0] rp, input bit rdy);
    fif.Stall      = st;
    fif.Redirect   = rd;
    fif.RedirectPC = rp;
    fif.ImemReady  = rdy;
    @(posedge Clk);
    #1;
  endtask

  localparam int NT = 19;
  bit          t_st  [NT] = '{0,0,0,1,0,0,0,0,1,0,0,1,0,0,0,0,0,0,0};
  bit          t_rd  [NT] = '{0,0,0,0,0,1,0,0,1,0,0,0,0,1,0,0,1,1,0};
  logic [31:0] t_rp  [NT] = '{0,0,0,0,0,32'h100,0,0,32'h200,0,0,0,0,32'hFFFF_FFFC,0,0,32'h33,32'h40,0};
  bit          t_rdy [NT] = '{1,1,0,1,1,0,0,1,1,1,1,0,1,1,1,1,1,1,1};

  initial begin
    Rst = 1'b1;
    wif.Stall = 1'b0; wif.Redirect = 1'b0; wif.RedirectPC = 32'h0; wif.ImemReady = 1'b1;
    cyc(0, 0, 32'h0, 1);
    cyc(0, 0, 32'h0, 1);
    // Reset state
    chk("rst_valid", 32'(fif.IfIdValid), 32'h0);
    chk("rst_addr",  fif.ImemAddr,       32'h0);
    chk("rst_pc",    fif.IfIdPC,         32'h0);
    chk("rst_instr", fif.IfIdInstr,      32'h0);
    chk("rst_pc4",   fif.IfIdPCPlus4,    32'h0);
    chk("rst_fault", 32'(fif.MisalignFault), 32'h0);
    chk("wrap_rst_addr", wif.ImemAddr,   32'hFFFF_FFFC);
    Rst = 1'b0;

    // Boot cycle then streaming fetch
    cyc(0, 0, 32'h0, 1);
    chk("boot_valid", 32'(fif.IfIdValid), 32'h0);
    chk("boot_addr",  fif.ImemAddr,       32'h0);
    cyc(0, 0, 32'h0, 1);
    chk("seq0_pc",    fif.IfIdPC,         32'h0);
    chk("seq0_pc4",   fif.IfIdPCPlus4,    32'h4);
    chk("seq0_instr", fif.IfIdInstr,      32'hA500_0000);
    chk("seq0_valid", 32'(fif.IfIdValid), 32'h1);
    chk("wrap_pc0",   wif.IfIdPC,         32'hFFFF_FFFC);
    chk("wrap_pc4_0", wif.IfIdPCPlus4,    32'h0);
    cyc(0, 0, 32'h0, 1);
    chk("seq1_pc",    fif.IfIdPC,         32'h4);
    chk("wrap_pc1",   wif.IfIdPC,         32'h0);
    chk("wrap_pc4_1", wif.IfIdPCPlus4,    32'h4);
    cyc(0, 0, 32'h0, 1);
    chk("seq2_pc",    fif.IfIdPC,         32'h8);
    chk("seq2_instr", fif.IfIdInstr,      32'hA500_0008);
    chk("seq2_addr",  fif.ImemAddr,       32'hC);

    // Stall two cycles with IF/ID holding 0x8
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 32'h0, 1);
      chk("stall_pc",    fif.IfIdPC,         32'h8);
      chk("stall_valid", 32'(fif.IfIdValid), 32'h1);
      chk("stall_addr",  fif.ImemAddr,       32'hC);
    end
    cyc(0, 0, 32'h0, 1);
    chk("post_stall_pc", fif.IfIdPC,   32'hC);
    chk("addr_10",       fif.ImemAddr, 32'h10);

    // Memory not ready for three cycles at 0x10
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 32'h0, 0);
      chk("wait_valid", 32'(fif.IfIdValid), 32'h0);
      chk("wait_addr",  fif.ImemAddr,       32'h10);
    end
    cyc(0, 0, 32'h0, 1);
    chk("wait_cap_pc",    fif.IfIdPC,         32'h10);
    chk("wait_cap_valid", 32'(fif.IfIdValid), 32'h1);

    // Redirect beats stall and discards returned data
    cyc(1, 1, 32'h400, 1);
    chk("redir_valid", 32'(fif.IfIdValid), 32'h0);
    chk("redir_addr",  fif.ImemAddr,       32'h400);
    cyc(0, 0, 32'h0, 1);
    chk("redir_pc",    fif.IfIdPC,         32'h400);
    chk("redir_vld2",  32'(fif.IfIdValid), 32'h1);

    // Misaligned redirect
    cyc(0, 1, 32'h402, 1);
    if (TRAP) begin
      chk("mis_fault", 32'(fif.MisalignFault), 32'h1);
      chk("mis_addr",  fif.ImemAddr,           32'h402);
      chk("mis_valid", 32'(fif.IfIdValid),     32'h0);
      cyc(0, 1, 32'h800, 1);
      chk("halt_addr",  fif.ImemAddr,           32'h402);
      chk("halt_fault", 32'(fif.MisalignFault), 32'h1);
      cyc(0, 0, 32'h0, 1);
      chk("halt_valid", 32'(fif.IfIdValid),     32'h0);
      chk("halt_addr2", fif.ImemAddr,           32'h402);
    end else begin
      chk("mis_addr",  fif.ImemAddr,           32'h400);
      chk("mis_fault", 32'(fif.MisalignFault), 32'h0);
      cyc(0, 0, 32'h0, 1);
      chk("mis_cap_pc", fif.IfIdPC,            32'h400);
    end

    // Reset in the middle of a fetch with ready asserted
    Rst = 1'b1;
    cyc(0, 0, 32'h0, 1);
    chk("mid_rst_valid", 32'(fif.IfIdValid),     32'h0);
    chk("mid_rst_addr",  fif.ImemAddr,           32'h0);
    chk("mid_rst_pc",    fif.IfIdPC,             32'h0);
    chk("mid_rst_fault", 32'(fif.MisalignFault), 32'h0);
    Rst = 1'b0;

    // Mixed directed table, checked by the model each cycle
    for (int i = 0; i < NT; i++) begin
      cyc(t_st[i], t_rd[i], t_rp[i], t_rdy[i]);
      if (i == 14) begin
        chk("tbl_wrap_pc",  fif.IfIdPC,      32'hFFFF_FFFC);
        chk("tbl_wrap_pc4", fif.IfIdPCPlus4, 32'h0);
      end
    end
    cyc(0, 0, 32'h0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
